// File: rtl/tdc_hit_collector_if.sv
// tdc_hit_collector_if: readout valid/ready handshake between the hit collector and the pixel readout
interface tdc_hit_collector_if;
  logic        outValid;
  logic        outReady;
  logic [41:0] outData;
  modport master (output outValid, output outData, input outReady);
  modport slave (input outValid, input outData, output outReady);
endinterface

// File: rtl/tdc_hit_collector.sv
// tdc_hit_collector: tags TDC hits with BCID and queues them in a FIFO for readout.
// Optional TOA acceptance window enabled by macro TDC_HIT_WINDOW_EN.
module tdc_hit_collector #(
  parameter int DEPTH    = 8,
  parameter int BCID_MAX = 3563
) (
  input  logic                    clk40,
  input  logic                    reset,
  input  logic                    hitFlag,
  input  logic [9:0]              TOA_codeReg,
  input  logic [8:0]              TOT_codeReg,
  input  logic [9:0]              Cal_codeReg,
  input  logic                    TOAerrorFlagReg,
  input  logic                    TOTerrorFlagReg,
  input  logic                    CalerrorFlagReg,
  input  logic [11:0]             bcidPreset,
  input  logic                    bcReset,
  input  logic [9:0]              winLow,
  input  logic [9:0]              winHigh,
  tdc_hit_collector_if.master     rd,
  output logic                    fifoFull,
  output logic                    fifoEmpty,
  output logic [15:0]             hitCount,
  output logic [15:0]             dropCount
);
  localparam int AW = $clog2(DEPTH);
  logic [11:0] bcid_q, bcid_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [41:0] mem [DEPTH];
  logic [41:0] head_q, head_d, word;
  logic [15:0] hit_q, hit_d, drop_q, drop_d;
  logic        pass, pop, push, drop;
`ifdef TDC_HIT_WINDOW_EN
  assign pass = (TOA_codeReg >= winLow) && (TOA_codeReg <= winHigh);
`else
  logic unused_win;
  assign unused_win = ^{winLow, winHigh};
  assign pass = 1'b1;
`endif
  assign fifoEmpty    = wptr_q == rptr_q;
  assign fifoFull     = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign rd.outValid  = ~fifoEmpty;
  assign rd.outData   = head_q;
  assign hitCount     = hit_q;
  assign dropCount    = drop_q;
  assign word = {bcid_q, TOAerrorFlagReg | TOTerrorFlagReg | CalerrorFlagReg,
                 Cal_codeReg, TOT_codeReg, TOA_codeReg};
  assign pop  = rd.outValid & rd.outReady;
  assign push = hitFlag & pass & (~fifoFull | pop);
  assign drop = hitFlag & pass & fifoFull & ~pop;
  always_comb begin
    bcid_d = bcReset ? bcidPreset : (bcid_q >= 12'(BCID_MAX)) ? 12'd0 : bcid_q + 12'd1;
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
    // head register tracks the post-edge head; bypass when the new word lands straight at the head
    head_d = (wptr_d == rptr_d) ? head_q :
             (push && rptr_d == wptr_q) ? word : mem[rptr_d[AW-1:0]];
    hit_d  = hit_q + 16'(push && hit_q != 16'hFFFF);
    drop_d = drop_q + 16'(drop && drop_q != 16'hFFFF);
  end
  always_ff @(posedge clk40) begin
    if (reset) begin
      bcid_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
      hit_q  <= '0;
      drop_q <= '0;
    end else begin
      bcid_q <= bcid_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
      hit_q  <= hit_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk40)
    if (push && !reset) mem[wptr_q[AW-1:0]] <= word;
endmodule
